fp_multiplier: RTL and testbench

Parameterised IEEE-754 binary floating-point multiplier. The default configuration is binary32. It supports normals, subnormals, signed zeros, infinities and NaN, and rounds to nearest, ties to even. The datapath is combinational and the result is registered once, giving a single-cycle-latency arithmetic unit for the FPU cluster.

---
 rtl/fp_multiplier.sv | 132 +++++++++++++
 tb/tb_fp_multiplier.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/fp_multiplier.sv
// IEEE-754 binary floating-point multiplier, round to nearest ties to even.
// Combinational datapath with a single output register (latency 1).
module fp_multiplier #(
    parameter int unsigned BITS          = 32,
    parameter int unsigned MANTISSA_BITS = 23,
    parameter int unsigned EXPONENT_BITS = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    input  logic [BITS-1:0] x,
    input  logic [BITS-1:0] y,
    output logic            out_valid,
    output logic [BITS-1:0] out
);

    localparam int unsigned M  = MANTISSA_BITS;
    localparam int unsigned E  = EXPONENT_BITS;
    localparam int unsigned SW = M + 1;              // significand incl. hidden bit
    localparam int unsigned PW = 2 * SW;             // full product width
    localparam int unsigned EW = E + 4;              // signed working exponent width
    localparam int unsigned LW = $clog2(SW + 1);     // leading-zero count width

    localparam logic signed [EW-1:0] BIAS = EW'((1 << (E - 1)) - 1);
    localparam logic signed [EW-1:0] EMAX = EW'((1 << E) - 1);
    localparam logic [BITS-1:0]      QNAN = {1'b0, {E{1'b1}}, 1'b1, {(M - 1){1'b0}}};

    function automatic logic [LW-1:0] lzc(input logic [SW-1:0] v);
        logic [LW-1:0] n;
        logic          hit;
        n   = '0;
        hit = 1'b0;
        for (int unsigned i = 0; i < SW; i++) begin
            if (!hit) begin
                if (v[SW-1-i]) hit = 1'b1;
                else           n   = n + LW'(1);
            end
        end
        return n;
    endfunction

    // operand fields and classification
    logic                 sx, sy, sr;
    logic [E-1:0]         ex, ey;
    logic [M-1:0]         fx, fy;
    logic                 x_nan, y_nan, x_inf, y_inf, x_zero, y_zero;
    logic [SW-1:0]        rawx, rawy, mx, my;
    logic [LW-1:0]        lzx, lzy;
    logic signed [EW-1:0] eax, eay;

    assign {sx, ex, fx} = x;
    assign {sy, ey, fy} = y;
    assign sr = sx ^ sy;

    assign x_nan  = (&ex) & (|fx);
    assign y_nan  = (&ey) & (|fy);
    assign x_inf  = (&ex) & ~(|fx);
    assign y_inf  = (&ey) & ~(|fy);
    assign x_zero = ~(|ex) & ~(|fx);
    assign y_zero = ~(|ey) & ~(|fy);

    // Subnormals use exponent 1 with hidden bit 0, then get left-normalised
    // so both significands enter the multiplier with the leading one at the top.
    assign rawx = {|ex, fx};
    assign rawy = {|ey, fy};
    assign lzx  = lzc(rawx);
    assign lzy  = lzc(rawy);
    assign mx   = rawx << lzx;
    assign my   = rawy << lzy;
    assign eax  = $signed((ex == '0) ? EW'(1) : EW'(ex)) - $signed(EW'(lzx));
    assign eay  = $signed((ey == '0) ? EW'(1) : EW'(ey)) - $signed(EW'(lzy));

    // product, normalisation, underflow and rounding
    logic [PW-1:0]        prod, pn, ws;
    logic signed [EW-1:0] be;
    logic [EW-1:0]        shamt;
    logic [E-1:0]         ebf;
    logic                 sticky, guard, rest, rnd_up, ovf;
    logic [SW-1:0]        m;
    logic [BITS-2:0]      mag;
    logic [BITS-1:0]      res;

    // Datapath: multiply, align leading one to the MSB, denormalise if tiny, round.
    always_comb begin
        prod   = PW'(mx) * PW'(my);
        pn     = prod[PW-1] ? prod : (prod << 1);
        be     = eax + eay - BIAS + $signed(EW'(prod[PW-1]));
        shamt  = '0;
        ws     = pn;
        sticky = 1'b0;
        ebf    = be[E-1:0];
        if (be < $signed(EW'(1))) begin
            // Shifts of PW or more leave ws = 0 and fold everything into sticky.
            shamt  = EW'($signed(EW'(1)) - be);
            ws     = pn >> shamt;
            sticky = |(pn & ~({PW{1'b1}} << shamt));
            ebf    = E'(1);
        end
        ovf    = (be >= EMAX);
        m      = ws[PW-1 -: SW];
        guard  = ws[M];
        rest   = (|ws[M-1:0]) | sticky;
        rnd_up = guard & (rest | m[0]);
        // Field = (ebf-1)<<M + significand: the hidden bit restores ebf for normals
        // and yields exponent 0 for subnormals; rounding carries ripple into the
        // exponent, giving min-normal or Inf exactly where IEEE expects them.
        mag    = {ebf - E'(1), {M{1'b0}}} + (BITS-1)'(m) + (BITS-1)'(rnd_up);

        if (x_nan | y_nan | (x_inf & y_zero) | (x_zero & y_inf))
            res = QNAN;
        else if (x_inf | y_inf)
            res = {sr, {E{1'b1}}, {M{1'b0}}};
        else if (x_zero | y_zero)
            res = {sr, {(BITS - 1){1'b0}}};
        else if (ovf)
            res = {sr, {E{1'b1}}, {M{1'b0}}};
        else
            res = {sr, mag};
    end

    // Output register: result every cycle, valid follows in_valid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out       <= '0;
            out_valid <= 1'b0;
        end else begin
            out       <= res;
            out_valid <= in_valid;
        end
    end

endmodule

// File: tb/tb_fp_multiplier.sv
module tb_fp_multiplier;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [31:0] x, y;
    logic [31:0] out;
    logic        out_valid;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    fp_multiplier #(.BITS(32), .MANTISSA_BITS(23), .EXPONENT_BITS(8)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid),
        .x(x), .y(y), .out_valid(out_valid), .out(out)
    );

    // apply one operand pair on the falling edge, return just after the next rising edge
    task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic v);
        @(negedge clk);
        x = a; y = b; in_valid = v;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b1; x = 32'h3FC00000; y = 32'h40000000;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (out !== 32'h0) begin fails++; $display("FAIL reset_out: got %h expected %h", out, 32'h0); end
        checks++;
        if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_basic();
        logic [31:0] va [0:4] = '{32'h3FC00000, 32'hC0000000, 32'h3F800001, 32'h80000000, 32'h007FFFFF};
        logic [31:0] vb [0:4] = '{32'h40000000, 32'h40400000, 32'h3F800001, 32'h40A00000, 32'h3F800001};
        logic [31:0] ve [0:4] = '{32'h40400000, 32'hC0C00000, 32'h3F800002, 32'h80000000, 32'h00800000};
        for (int i = 0; i < 5; i++) begin
            drive(va[i], vb[i], 1'b1);
            checks++;
            if (out !== ve[i]) begin
                fails++; $display("FAIL basic[%0d] %h*%h: got %h expected %h", i, va[i], vb[i], out, ve[i]);
            end
            checks++;
            if (out_valid !== 1'b1) begin fails++; $display("FAIL basic_valid[%0d]: got %b expected 1", i, out_valid); end
        end
    endtask

    task automatic test_special();
        logic [31:0] va [0:7] = '{32'h7F800000, 32'h00000000, 32'h7FC00000, 32'hFFC00000,
                                  32'h7FC00001, 32'h7F800000, 32'h7F7FFFFF, 32'hFF7FFFFF};
        logic [31:0] vb [0:7] = '{32'h00000000, 32'hFF800000, 32'h3F800000, 32'h3F800000,
                                  32'h00000000, 32'hC0000000, 32'h40000000, 32'h40000000};
        logic [31:0] ve [0:7] = '{32'h7FC00000, 32'h7FC00000, 32'h7FC00000, 32'h7FC00000,
                                  32'h7FC00000, 32'hFF800000, 32'h7F800000, 32'hFF800000};
        for (int i = 0; i < 8; i++) begin
            drive(va[i], vb[i], 1'b1);
            checks++;
            if (out !== ve[i]) begin
                fails++; $display("FAIL special[%0d] %h*%h: got %h expected %h", i, va[i], vb[i], out, ve[i]);
            end
        end
    endtask

    task automatic test_subnormal();
        logic [31:0] va [0:3] = '{32'h00800000, 32'h00000001, 32'h00000003, 32'h00000001};
        logic [31:0] vb [0:3] = '{32'h3F000000, 32'h3F000000, 32'h3F000000, 32'h4B000000};
        logic [31:0] ve [0:3] = '{32'h00400000, 32'h00000000, 32'h00000002, 32'h00800000};
        for (int i = 0; i < 4; i++) begin
            drive(va[i], vb[i], 1'b1);
            checks++;
            if (out !== ve[i]) begin
                fails++; $display("FAIL subnormal[%0d] %h*%h: got %h expected %h", i, va[i], vb[i], out, ve[i]);
            end
        end
    endtask

    task automatic test_valid_gap();
        drive(32'h40000000, 32'h40400000, 1'b0);
        checks++;
        if (out_valid !== 1'b0) begin fails++; $display("FAIL gap_valid: got %b expected 0", out_valid); end
        checks++;
        if (out !== 32'h40C00000) begin fails++; $display("FAIL gap_out: got %h expected %h", out, 32'h40C00000); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] va [0:2] = '{32'h40000000, 32'h3F000000, 32'hBFC00000};
        logic [31:0] vb [0:2] = '{32'h40000000, 32'h3F000000, 32'h3FC00000};
        logic [31:0] ve [0:2] = '{32'h40800000, 32'h3E800000, 32'hC0100000};
        for (int i = 0; i < 3; i++) begin
            drive(va[i], vb[i], 1'b1);
            checks++;
            if (out !== ve[i] || out_valid !== 1'b1) begin
                fails++; $display("FAIL b2b[%0d]: got %h/%b expected %h/1", i, out, out_valid, ve[i]);
            end
        end
    endtask

    task automatic test_reset_midstream();
        drive(32'h3FC00000, 32'h40000000, 1'b1);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (out !== 32'h0 || out_valid !== 1'b0) begin
            fails++; $display("FAIL async_reset: got %h/%b expected 00000000/0", out, out_valid);
        end
        @(posedge clk);
        #1;
        checks++;
        if (out !== 32'h0 || out_valid !== 1'b0) begin
            fails++; $display("FAIL reset_hold: got %h/%b expected 00000000/0", out, out_valid);
        end
        @(negedge clk);
        reset = 1'b0;
        x = 32'hC0000000; y = 32'h40400000; in_valid = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (out !== 32'hC0C00000 || out_valid !== 1'b1) begin
            fails++; $display("FAIL post_reset: got %h/%b expected c0c00000/1", out, out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_special();
        test_subnormal();
        test_valid_gap();
        test_back_to_back();
        test_reset_midstream();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
